dx_iobus_ctrl: RTL and testbench

DX_IOBUS_CTRL -- requirements
Module: dx_iobus_ctrl

---
 rtl/dx_iobus_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dx_iobus_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dx_iobus_ctrl.sv
// Tristate I/O bus controller: command/response front end driving a dx_iobuf.
// Optional macro DX_IOBUS_SYNC_EN adds a two-flop synchroniser on dio_i.
module dx_iobus_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int HOLD_CYCLES = 1,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_wr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [DATA_WIDTH-1:0] dio_t,
    output logic [DATA_WIDTH-1:0] dio_o,
    input  logic [DATA_WIDTH-1:0] dio_i,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        TURN,
        SAMPLE,
        RESP
    } state_t;

`ifdef DX_IOBUS_SYNC_EN
    localparam int SYNC_XTRA = 2;
`else
    localparam int SYNC_XTRA = 0;
`endif

    localparam logic [3:0] HOLD_LD    = 4'(HOLD_CYCLES - 1);
    localparam logic [3:0] TURN_WR_LD = 4'(TURN_CYCLES - 1);
    localparam logic [3:0] TURN_RD_LD = 4'(TURN_CYCLES - 1 + SYNC_XTRA);

    if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
        $error("dx_iobus_ctrl: HOLD_CYCLES out of range 1..15");
    end
    if (TURN_CYCLES < 1 || TURN_CYCLES + SYNC_XTRA > 16) begin : g_bad_turn
        $error("dx_iobus_ctrl: TURN_CYCLES out of range for 4-bit counter");
    end

    state_t                  state_q;
    state_t                  state_d;
    logic [3:0]              cnt_q;
    logic [3:0]              cnt_d;
    logic                    wr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [DATA_WIDTH-1:0]   bus_in;
    logic                    accept;
    logic                    drive;

`ifdef DX_IOBUS_SYNC_EN
    logic [DATA_WIDTH-1:0] sync1_q;
    logic [DATA_WIDTH-1:0] sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= dio_i;
            sync2_q <= sync1_q;
        end
    end

    assign bus_in = sync2_q;
`else
    assign bus_in = dio_i;
`endif

    assign accept = (state_q == IDLE) && cmd_valid;

    // Counter holds remaining cycles minus one; a state exits when it reads zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_wr) begin
                        state_d = DRIVE;
                        cnt_d   = HOLD_LD;
                    end else begin
                        state_d = TURN;
                        cnt_d   = TURN_RD_LD;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = TURN;
                    cnt_d   = TURN_WR_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            TURN: begin
                if (cnt_q == 4'd0) begin
                    state_d = wr_q ? IDLE : SAMPLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            SAMPLE: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= 1'b0;
            wdata_q <= '0;
        end else if (accept) begin
            wr_q    <= cmd_wr;
            wdata_q <= cmd_wr ? cmd_wdata : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (state_q == SAMPLE) begin
            rdata_q <= bus_in;
        end
    end

    // Outputs decode straight from state so reset releases the bus at once.
    assign drive     = (state_q == DRIVE);
    assign dio_t     = {DATA_WIDTH{~drive}};
    assign dio_o     = drive ? wdata_q : '0;
    assign busy      = (state_q != IDLE);
    assign cmd_ready = rst_n && (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_dx_iobus_ctrl.sv
// Directed bench for dx_iobus_ctrl with a dx_iobuf pad model.
// Expected values are derived from HOLD/TURN parameters below.
module tb_dx_iobus_ctrl;

    localparam int W    = 8;
    localparam int HOLD = 1;
    localparam int TURN = 2;
`ifdef DX_IOBUS_SYNC_EN
    localparam int RD_LAT = TURN + 3;
`else
    localparam int RD_LAT = TURN + 1;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic         cmd_wr = 1'b0;
    logic [W-1:0] cmd_wdata = '0;
    logic         rsp_valid;
    logic         rsp_ready = 1'b0;
    logic [W-1:0] rsp_rdata;
    logic [W-1:0] dio_t;
    logic [W-1:0] dio_o;
    logic [W-1:0] dio_i;
    logic         busy;

    logic [W-1:0] bench_val = '0;
    logic         rd_pending;
    int           nchk = 0;
    int           nerr = 0;
    int           contention = 0;
    int           split = 0;
    int           dirty = 0;

    dx_iobus_ctrl #(
        .DATA_WIDTH (W),
        .HOLD_CYCLES(HOLD),
        .TURN_CYCLES(TURN)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_wr   (cmd_wr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .dio_t    (dio_t),
        .dio_o    (dio_o),
        .dio_i    (dio_i),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Device drives the pad from read accept until the response is taken.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rd_pending <= 1'b0;
        else if (cmd_valid && cmd_ready && !cmd_wr)
            rd_pending <= 1'b1;
        else if (rsp_valid && rsp_ready)
            rd_pending <= 1'b0;
    end

    assign dio_i = (~dio_t & dio_o) |
                   (dio_t & (rd_pending ? bench_val : '0));

    always @(posedge clk) begin
        if (rd_pending && dio_t != '1) contention++;
        if (dio_t != '0 && dio_t != '1) split++;
        if (dio_t == '1 && dio_o != '0) dirty++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_idle(output int k);
        k = 0;
        while (!cmd_ready && k < 40) begin
            tick();
            k++;
        end
    endtask

    initial begin
        int lat;
        int k;
        int n_rel;
        int seen;
        logic [W-1:0] wd;

        #1 rst_n = 1'b0;
        #2;
        chk("rst_dio_t", dio_t, 8'hFF);
        chk("rst_dio_o", dio_o, 8'h00);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 8'h00);
        chk("rst_busy", busy, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        #19 rst_n = 1'b1;
        #1;
        chk("post_rst_ready", cmd_ready, 1);
        tick();

        // Single write of 0xA5
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_wdata = 8'hA5;
        tick();
        cmd_valid = 1'b0;
        chk("wr_drive_t", dio_t, 8'h00);
        chk("wr_drive_o", dio_o, 8'hA5);
        chk("wr_busy", busy, 1);
        chk("wr_no_ready", cmd_ready, 0);
        for (int i = 1; i < HOLD; i++) begin
            tick();
            chk("wr_hold_t", dio_t, 8'h00);
        end
        for (int i = 0; i < TURN; i++) begin
            tick();
            chk("wr_turn_t", dio_t, 8'hFF);
            chk("wr_turn_o", dio_o, 8'h00);
            chk("wr_turn_busy", busy, 1);
        end
        tick();
        chk("wr_done_ready", cmd_ready, 1);
        chk("wr_done_busy", busy, 0);

        // Single read returning 0x3C, response stalled 10 cycles
        bench_val = 8'h3C;
        cmd_valid = 1'b1; cmd_wr = 1'b0;
        tick();
        cmd_valid = 1'b0;
        chk("rd_released", dio_t, 8'hFF);
        chk("rd_no_valid", rsp_valid, 0);
        wait_rsp(lat);
        chk("rd_latency", lat, RD_LAT);
        chk("rd_data", rsp_rdata, 8'h3C);
        bench_val = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_valid", rsp_valid, 1);
            chk("stall_data", rsp_rdata, 8'h3C);
            chk("stall_ready", cmd_ready, 0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("rsp_taken_valid", rsp_valid, 0);
        chk("rsp_taken_ready", cmd_ready, 1);

        // Write then read, cmd_valid held high
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_wdata = 8'h5A;
        tick();
        cmd_wr = 1'b0;
        bench_val = 8'hC3;
        chk("b2b_wr_o", dio_o, 8'h5A);
        n_rel = 0;
        k = 0;
        while (!cmd_ready && k < 40) begin
            if (dio_t == '1) n_rel++;
            tick();
            k++;
        end
        chk("b2b_released", n_rel, TURN);
        tick();
        cmd_valid = 1'b0;
        wait_rsp(lat);
        chk("b2b_rd_lat", lat, RD_LAT);
        chk("b2b_rd_data", rsp_rdata, 8'hC3);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset asserted while driving
        cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_wdata = 8'h99;
        tick();
        cmd_valid = 1'b0;
        chk("mid_drive_t", dio_t, 8'h00);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_t", dio_t, 8'hFF);
        chk("mid_rst_o", dio_o, 8'h00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", cmd_ready, 0);
        #10 rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", seen, 0);
        chk("mid_rst_idle", cmd_ready, 1);

        // Random write/read mix
        for (int n = 0; n < 1000; n++) begin
            wd = W'($urandom);
            bench_val = W'($urandom);
            cmd_wr = 1'($urandom_range(0, 1));
            cmd_wdata = wd;
            cmd_valid = 1'b1;
            tick();
            cmd_valid = 1'b0;
            if (cmd_wr) begin
                chk("rand_wr_o", dio_o, 32'(wd));
                wait_idle(k);
                chk("rand_wr_busy", k, HOLD + TURN);
            end else begin
                wait_rsp(lat);
                chk("rand_rd_data", rsp_rdata, 32'(bench_val));
                repeat ($urandom_range(0, 2)) tick();
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                chk("rand_rd_idle", cmd_ready, 1);
            end
        end

        chk("contention", contention, 0);
        chk("split_dio_t", split, 0);
        chk("dio_o_when_released", dirty, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
